// File: rtl/k2_step_pkg.sv
// Shared types and defaults for the K2 single-step button front end.
// Holds the debounce FSM state encoding and the step counter width.
package k2_step_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } step_state_t;

  localparam int DB_CYCLES_DEFAULT = 1_000_000;
  localparam int RUN_DIV_DEFAULT   = 50_000_000;
  localparam int STEP_CNT_W        = 16;

  // Debounced level implied by a state: high once a press has been accepted.
  function automatic logic level_of(input step_state_t st);
    case (st)
      PRESSED, RELEASE_WAIT: level_of = 1'b1;
      default:               level_of = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous board inputs
// (push-button and slide switches), asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/btn_step_ctrl.sv
// Debounced single-step pulse generator for the K2 core, with step counter.
// Optional auto-run divider is built only when AUTO_RUN_EN is defined.
module btn_step_ctrl
  import k2_step_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int RUN_DIV   = RUN_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_in,
  input  logic                  run_mode,
  output logic                  step_en,
  output logic                  btn_level,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                  btn_s;
  step_state_t           state_r;
  step_state_t           state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic                  press_pulse_s;
  logic                  step_pulse_s;
  logic                  step_en_r;
  logic                  btn_level_r;
  logic [STEP_CNT_W-1:0] step_count_r;

  sync_2ff u_btn_sync (
    .clk (clk),
    .rst (reset),
    .d   (btn_in),
    .q   (btn_s)
  );

  // Debounce FSM state and stability counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: a level change is accepted only after DB_CYCLES stable samples.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    press_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (btn_s) begin
          state_nxt_s = PRESS_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = PRESSED;
          cnt_nxt_s     = CNT_ZERO;
          press_pulse_s = 1'b1;
        end else begin
          state_nxt_s = PRESS_WAIT;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        cnt_nxt_s = CNT_ZERO;
        if (!btn_s) begin
          state_nxt_s = RELEASE_WAIT;
        end else begin
          state_nxt_s = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: back to PRESSED without a fresh pulse.
          state_nxt_s = PRESSED;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = RELEASE_WAIT;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

`ifdef AUTO_RUN_EN
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic             run_s;
  logic [DIV_W-1:0] div_r;

  sync_2ff u_run_sync (
    .clk (clk),
    .rst (reset),
    .d   (run_mode),
    .q   (run_s)
  );

  // Auto-run period divider, parked at zero whenever auto-run is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= DIV_ZERO;
    end else if (!run_s) begin
      div_r <= DIV_ZERO;
    end else if (div_r == DIV_LAST) begin
      div_r <= DIV_ZERO;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // In auto-run the divider wrap replaces button presses as the step source.
  always_comb begin
    step_pulse_s = 1'b0;
    if (run_s) begin
      step_pulse_s = (div_r == DIV_LAST);
    end else begin
      step_pulse_s = press_pulse_s;
    end
  end
`else
  logic unused_run_mode_s;
  assign unused_run_mode_s = run_mode;
  assign step_pulse_s      = press_pulse_s;
`endif

  // Registered outputs: step pulse, debounced level and wrapping step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_en_r    <= 1'b0;
      btn_level_r  <= 1'b0;
      step_count_r <= {STEP_CNT_W{1'b0}};
    end else begin
      step_en_r   <= step_pulse_s;
      btn_level_r <= level_of(state_nxt_s);
      if (step_pulse_s) begin
        step_count_r <= step_count_r + STEP_CNT_W'(1);
      end
    end
  end

  assign step_en    = step_en_r;
  assign btn_level  = btn_level_r;
  assign step_count = step_count_r;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Scoreboard bench for btn_step_ctrl (button-only build, DB_CYCLES=4).
`timescale 1ns/1ps
module tb_btn_step_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_in;
  logic        run_mode;
  logic        step_en;
  logic        btn_level;
  logic [15:0] step_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    time         t;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: a level flips after DB+1 consecutive synchronized samples
  // disagreeing with it; every accepted rising flip is one step.
  bit          m_sync1;
  bit          m_sync2;
  bit          m_level;
  int          m_run;
  logic [15:0] m_count;

  btn_step_ctrl #(.DB_CYCLES(DB), .RUN_DIV(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .run_mode   (run_mode),
    .step_en    (step_en),
    .btn_level  (btn_level),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sync1 = 1'b0;
    m_sync2 = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
    m_count = 16'h0000;
    exp_q.delete();
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // One clock: drive at negedge (caller is there), update model at posedge, check level.
  task automatic cyc(input bit b);
    bit smp;
    btn_in = b;
    @(posedge clk);
    smp     = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = b;
    if (smp != m_level) m_run++;
    else m_run = 0;
    if (m_run == DB + 1) begin
      m_level = smp;
      m_run   = 0;
      if (smp) begin
        m_count = m_count + 16'd1;
        exp_q.push_back('{$time, m_count});
      end
    end
    #1;
    check_val("btn_level", {15'd0, btn_level}, {15'd0, m_level});
    @(negedge clk);
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) cyc(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_val("rst_step_en", {15'd0, step_en}, 16'd0);
    check_val("rst_btn_level", {15'd0, btn_level}, 16'd0);
    check_val("rst_step_count", step_count, 16'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every step_en pulse must match the oldest expected step.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0 && exp_q[0].t < $time - 1) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: step_en stayed 0, expected at %0t count %h", e.t, e.cnt);
    end
    if (step_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse at %0t: step_en 1 expected 0 (count %h)", $time, step_count);
      end else begin
        e = exp_q.pop_front();
        if (e.t != $time - 1 || step_count !== e.cnt) begin
          errors++;
          $display("FAIL pulse at %0t count %h, expected at %0t count %h", $time - 1, step_count, e.t, e.cnt);
        end
      end
    end else if (step_en !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL step_en_x at %0t: got %b expected 0/1", $time, step_en);
    end
  end

  initial begin
    reset    = 1'b1;
    btn_in   = 1'b0;
    run_mode = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Clean long press then release
    hold(1'b1, 20);
    hold(1'b0, 15);
    check_val("count_after_press", step_count, 16'd1);

    // Short glitches that must be rejected
    hold(1'b1, 1); hold(1'b0, 6);
    hold(1'b1, 2); hold(1'b0, 6);
    hold(1'b1, 3); hold(1'b0, 10);
    check_val("count_after_glitches", step_count, 16'd1);

    // Accepted press, 2-cycle release glitch, continued hold
    hold(1'b1, 10);
    hold(1'b0, 2);
    hold(1'b1, 15);
    check_val("level_through_glitch", {15'd0, btn_level}, 16'd1);
    hold(1'b0, 15);
    check_val("count_after_rel_glitch", step_count, 16'd2);

    // Random bouncing segments
    for (int s = 0; s < 300; s++) begin
      hold(1'(s % 2 == 0), int'($urandom_range(1, 10)));
    end
    hold(1'b0, 15);

    // Counter wrap from 0xFFFF
    force dut.step_count_r = 16'hFFFF;
    #1;
    release dut.step_count_r;
    m_count = 16'hFFFF;
    @(negedge clk);
    hold(1'b1, 10);
    hold(1'b0, 15);
    check_val("count_wrap", step_count, 16'h0000);

    // Reset in PRESS_WAIT with counter at 2, button kept high
    hold(1'b1, 2);
    hold(1'b0, 10);
    hold(1'b1, 5);
    do_reset();
    hold(1'b1, 12);
    check_val("count_after_reset_press", step_count, 16'd1);
    hold(1'b0, 15);

    check_val("final_count", step_count, m_count);
    check_val("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
